// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and access sequencer that sits between two requesters and a
// single synchronous word-access data memory. It validates each address and returns a registered completion.
module data_mem_arbiter #(
    parameter int MEM_BYTES = 101
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic [7:0]  o_err_count,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_r_en,
    output logic        o_mem_w_en,
    input  logic [31:0] i_mem_data
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_REJ   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_last_owner;
    logic        r_owner;
    logic        r_we;
    logic        r_done0;
    logic        r_done1;
    logic        r_err0;
    logic        r_err1;
    logic [31:0] r_rdata;
    logic        r_busy;
    logic [7:0]  r_err_count;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_write_data;
    logic        r_mem_r_en;
    logic        r_mem_w_en;

    logic        w_any;
    logic        w_winner;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_legal;

    // On a tie the requester that did not win last time is granted.
    assign w_any       = i_req0 | i_req1;
    assign w_winner    = (i_req0 & i_req1) ? ~r_last_owner : i_req1;
    assign w_sel_we    = w_winner ? i_we1    : i_we0;
    assign w_sel_addr  = w_winner ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_winner ? i_wdata1 : i_wdata0;
    assign w_legal     = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr <= LAST_ADDR);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state          <= S_IDLE;
            r_last_owner     <= 1'b1;
            r_owner          <= 1'b0;
            r_we             <= 1'b0;
            r_done0          <= 1'b0;
            r_done1          <= 1'b0;
            r_err0           <= 1'b0;
            r_err1           <= 1'b0;
            r_rdata          <= 32'd0;
            r_busy           <= 1'b0;
            r_err_count      <= 8'd0;
            r_mem_address    <= 32'd0;
            r_mem_write_data <= 32'd0;
            r_mem_r_en       <= 1'b0;
            r_mem_w_en       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_we         <= w_sel_we;
                        r_busy       <= 1'b1;
                        if (w_legal) begin
                            r_mem_address    <= w_sel_addr;
                            r_mem_write_data <= w_sel_wdata;
                            r_mem_r_en       <= ~w_sel_we;
                            r_mem_w_en       <= w_sel_we;
                            r_state          <= S_ISSUE;
                        end else begin
                            // Rejection completes in the very next cycle; memory is never touched.
                            r_done0 <= ~w_winner;
                            r_done1 <= w_winner;
                            r_err0  <= ~w_winner;
                            r_err1  <= w_winner;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state <= S_REJ;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_r_en <= 1'b0;
                    r_mem_w_en <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (!r_we) begin
                        r_rdata <= i_mem_data;
                    end
                    r_done0 <= ~r_owner;
                    r_done1 <= r_owner;
                    r_state <= S_RESP;
                end
                S_RESP, S_REJ: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_done0          = r_done0;
    assign o_done1          = r_done1;
    assign o_err0           = r_err0;
    assign o_err1           = r_err1;
    assign o_rdata          = r_rdata;
    assign o_busy           = r_busy;
    assign o_err_count      = r_err_count;
    assign o_mem_address    = r_mem_address;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_r_en       = r_mem_r_en;
    assign o_mem_w_en       = r_mem_w_en;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 101-byte big-endian synchronous memory model.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1, busy, mem_r_en, mem_w_en;
    logic [31:0] rdata, mem_address, mem_write_data;
    logic [31:0] mem_data = '0;
    logic [7:0]  err_count;

    logic [7:0]  mem [0:100];
    logic        oob_seen = 1'b0;
    logic        both_en_seen = 1'b0;
    int          tests = 0;
    int          fails = 0;

    data_mem_arbiter #(.MEM_BYTES(101)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(done0), .o_done1(done1), .o_err0(err0), .o_err1(err1),
        .o_rdata(rdata), .o_busy(busy), .o_err_count(err_count),
        .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
        .o_mem_r_en(mem_r_en), .o_mem_w_en(mem_w_en), .i_mem_data(mem_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        int a;
        a = int'(mem_address);
        if (mem_w_en) begin
            if (a >= 0 && a + 3 <= 100) begin
                {mem[a], mem[a+1], mem[a+2], mem[a+3]} = mem_write_data;
            end else begin
                oob_seen = 1'b1;
            end
        end
        if (mem_r_en) begin
            if (a >= 0 && a + 3 <= 100) begin
                mem_data <= {mem[a], mem[a+1], mem[a+2], mem[a+3]};
            end else begin
                oob_seen = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_r_en && mem_w_en) both_en_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issues one request and samples each cycle after the sampling edge until its done.
    task automatic access(input int who, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] rd, output int n_r, output int n_w,
                          output int en_cyc, output int other_done, output int busy1);
        @(negedge clk);
        if (who == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end
        lat = -1; err = 1'b0; rd = '0; n_r = 0; n_w = 0; en_cyc = -1; other_done = 0; busy1 = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = int'(busy);
            if ((mem_r_en || mem_w_en) && en_cyc < 0) en_cyc = c;
            n_r += int'(mem_r_en);
            n_w += int'(mem_w_en);
            if ((who == 0 && done1) || (who == 1 && done0)) other_done++;
            if ((who == 0 && done0) || (who == 1 && done1)) begin
                lat = c;
                err = (who == 0) ? err0 : err1;
                rd  = rdata;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    typedef struct {
        int          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          lat, n_r, n_w, en_cyc, other, busy1, g, dcount;
        logic        err;
        logic [31:0] rd;

        for (int i = 0; i <= 100; i++) mem[i] = 8'(i);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        vecs[0]  = '{0, 1'b0, 32'd0,   32'd0,         1'b0, 1'b1, 32'h11223344, 8'd0};
        vecs[1]  = '{1, 1'b1, 32'd96,  32'hDEADBEEF,  1'b0, 1'b1, 32'h11223344, 8'd0};
        vecs[2]  = '{1, 1'b0, 32'd96,  32'd0,         1'b0, 1'b1, 32'hDEADBEEF, 8'd0};
        vecs[3]  = '{0, 1'b0, 32'd4,   32'd0,         1'b0, 1'b1, 32'h04050607, 8'd0};
        vecs[4]  = '{0, 1'b1, 32'd4,   32'hCAFEF00D,  1'b0, 1'b1, 32'h04050607, 8'd0};
        vecs[5]  = '{1, 1'b0, 32'd4,   32'd0,         1'b0, 1'b1, 32'hCAFEF00D, 8'd0};
        vecs[6]  = '{0, 1'b0, 32'd6,   32'd0,         1'b1, 1'b0, 32'd0,        8'd1};
        vecs[7]  = '{0, 1'b0, 32'd100, 32'd0,         1'b1, 1'b0, 32'd0,        8'd2};
        vecs[8]  = '{1, 1'b1, 32'd97,  32'h55555555,  1'b1, 1'b0, 32'd0,        8'd3};
        vecs[9]  = '{1, 1'b0, 32'hFFFFFFFC, 32'd0,    1'b1, 1'b0, 32'd0,        8'd4};
        vecs[10] = '{0, 1'b0, 32'd92,  32'd0,         1'b0, 1'b1, 32'h5C5D5E5F, 8'd4};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {28'd0, done0, done1, err0, err1}, 32'd0);
        check("rst_en_busy", {29'd0, mem_r_en, mem_w_en, busy}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        rst_n = 1'b1;

        // Both requesters held high: grants alternate starting with requester 0
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd96;
        g = 0;
        for (int c = 0; c < 60 && g < 4; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                check($sformatf("tie_grant%0d", g), {31'd0, done1}, 32'(g % 2));
                check($sformatf("tie_single_done%0d", g), {31'd0, done0 & done1}, 32'd0);
                check($sformatf("tie_rdata%0d", g), rdata, (g % 2 == 0) ? 32'h11223344 : 32'h60616263);
                g++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("tie_grant_count", 32'(g), 32'd4);
        repeat (2) @(negedge clk);

        // Single-requester vectors
        for (int i = 0; i < 11; i++) begin
            access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   lat, err, rd, n_r, n_w, en_cyc, other, busy1);
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd3);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_r_en_pulses", i), 32'(n_r), (!vecs[i].exp_err && !vecs[i].we) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_w_en_pulses", i), 32'(n_w), (!vecs[i].exp_err && vecs[i].we) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_en_cycle", i), 32'(en_cyc), vecs[i].exp_err ? 32'hFFFFFFFF : 32'd1);
            check($sformatf("v%0d_other_done", i), 32'(other), 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy1), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_err_count", i), {24'd0, err_count}, {24'd0, vecs[i].exp_cnt});
        end
        check("mem96_written", {mem[96], mem[97], mem[98], mem[99]}, 32'hDEADBEEF);

        // Reset in the middle of ISSUE for a write
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = 32'h12345678;
        @(posedge clk);
        #2;
        check("abort_in_issue", {31'd0, mem_w_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_w_en_drop", {31'd0, mem_w_en}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dcount += int'(done0) + int'(done1);
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_mem_intact", {mem[8], mem[9], mem[10], mem[11]}, 32'h08090A0B);
        check("abort_err_count_clr", {24'd0, err_count}, 32'd0);

        // Tie right after reset goes to requester 0 and reads the old word at 8
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd8;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done0 || done1) begin
                lat = c;
                check("post_rst_tie_winner", {30'd0, done1, done0}, 32'd1);
                check("post_rst_read8", rdata, 32'h08090A0B);
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("post_rst_latency", 32'(lat), 32'd3);
        repeat (3) @(negedge clk);

        check("no_out_of_range_access", {31'd0, oob_seen}, 32'd0);
        check("enables_never_together", {31'd0, both_en_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port round-robin arbiter and sequencer in front of the byte-addressed, word-access data memory (101 bytes, synchronous read and write on the rising clock edge). It connects the pipeline MEM stage (requester 0) and the program/data loader (requester 1) to the single memory port. It validates each word address, drives the memory enables for exactly one cycle per access, and returns a registered completion with read data. Illegal addresses are rejected without touching memory.

## Interface
- MEM_BYTES, default 101: memory size in bytes; the last legal word address is the largest multiple of 4 ≤ MEM_BYTES-4 (96 at the default size).
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; all registers clear immediately while low.
- req0 / req1  in  1  access request; held high until the matching done.
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high.
- addr0 / addr1  in  32  byte address of the word.
- wdata0 / wdata1  in  32  write data.
- done0 / done1  out  1  one-cycle completion pulse to the owning requester.
- err0 / err1  out  1  high with done when the request was rejected.
- rdata  out  32  read data; valid while done_x is high on a read.
- busy  out  1  high in every state except IDLE.
- err_count  out  8  saturating count of rejected requests.
- mem_address  out  32  memory address.
- mem_write_data  out  32  memory write data.
- mem_r_en / mem_w_en  out  1  memory enables.
- mem_data  in  32  memory read data, valid the cycle after mem_r_en.

## Operation
- States are IDLE, ISSUE, WAIT, RESP and REJ. Every output is registered.
- **IDLE:**
  - At a rising edge with any req high, select an owner.
  - If only one requester is high, that requester wins.
  - If both are high, the requester other than last_owner wins.
  - After selection, last_owner takes the winner's index.
  - The winner's we, addr and wdata are latched.
- **Legality check:** the address is legal when addr[1:0]==0 and addr ≤ MEM_BYTES-4.
  - A legal request moves to ISSUE.
  - An illegal request moves to REJ.
- **ISSUE** (1 cycle):
  - mem_address and mem_write_data carry the latched values.
  - Exactly one of mem_r_en or mem_w_en is high, chosen by the latched we.
  - Next state is WAIT.
- **WAIT** (1 cycle):
  - Both enables are low.
  - mem_data is valid in this cycle; on a read, rdata <= mem_data at the edge ending WAIT.
  - Next state is RESP.
- **RESP** (1 cycle):
  - done_owner=1 and err_owner=0.
  - On a write, rdata holds its previous value.
  - Next state is IDLE.
- **REJ** (1 cycle):
  - done_owner=1 and err_owner=1.
  - No memory enable is asserted.
  - err_count increments and saturates at 255.
  - Next state is IDLE.
- Rejected requests still update last_owner, so fairness is preserved.
- The non-owner's request is ignored until the controller returns to IDLE. Its done stays low throughout.
- Requester protocol: drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- mem_address and mem_write_data hold their last values outside ISSUE.
- Reset values:
  - State = IDLE and last_owner = 1, so requester 0 wins the first tie.
  - All done, err and enable outputs = 0.
  - rdata, mem_address, mem_write_data and err_count = 0; busy = 0.
- Reset while low clears mem_r_en and mem_w_en immediately. A write in ISSUE is performed only if the edge ending ISSUE occurs with reset high. No done is issued for an aborted access. Memory contents are not cleared by this block.

## Timing
- Legal access: req sampled at edge E0, then ISSUE is cycle 1, WAIT cycle 2, and done in cycle 3.
- Latency is 3 cycles from the sampling edge for both reads and writes.
- Illegal access: done and err appear in cycle 1 after E0.
- Back-to-back legal accesses: a new ISSUE at most every 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Enables are never high for more than one consecutive cycle. mem_r_en and mem_w_en are never high together.

## Test plan
- Reset, then req0 read at addr 0 with memory bytes 0..3 = 11,22,33,44. Required: mem_r_en pulses in cycle 1; done0=1, err0=0 and rdata=0x11223344 in cycle 3.
- req1 writes 0xDEADBEEF to addr 96, then req1 reads addr 96. Required: mem_w_en pulses once; the read returns 0xDEADBEEF; err_count stays 0.
- req0 and req1 both held high continuously after reset. Required: grants go 0,1,0,1 with done pulses alternating; the other done stays low.
- req0 to addr 6 (misaligned) and then addr 100 (out of range). Required: done0=1 and err0=1 one cycle after sampling; no enable ever asserts; err_count = 2.
- Reset asserted mid-ISSUE of a write of 0x12345678 to addr 8. Required: mem_w_en drops immediately; no done; a subsequent read of addr 8 returns the old value. After reset, a tie is granted to req0.
